// File: rtl/poker_pkg.sv
// poker_pkg: card encoding, deck constants and FSM states shared by dealer and classifier
package poker_pkg;
  typedef logic [5:0] card_t;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  localparam logic [3:0] RANK_MIN = 4'd1;
  localparam logic [3:0] RANK_MAX = 4'd13;
  localparam int DECK_N = 52;
  localparam int HAND_N = 5;
  localparam logic [3:0] HANDS_FULL = 4'(DECK_N / HAND_N);
  function automatic logic [5:0] card_idx(card_t c);
    return 6'(c[5:4]) * 6'd13 + 6'(c[3:0]) - 6'd1;
  endfunction
endpackage

// File: rtl/poker_lfsr.sv
// poker_lfsr: loadable Fibonacci LFSR x^16+x^14+x^13+x^11+1 that advances only when stepped
module poker_lfsr #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= SEED;
    else if (load) q <= seed;
    else if (step) q <= {q[LFSR_W-2:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/poker_dealer.sv
// poker_dealer: deals 5 distinct cards per hand from one 52-card deck; POKER_DEALER_PRESET_EN adds a preset-hand load
module poker_dealer
  import poker_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  output logic              hand_valid,
  input  logic              hand_ready,
  output logic [5:0]        card0,
  output logic [5:0]        card1,
  output logic [5:0]        card2,
  output logic [5:0]        card3,
  output logic [5:0]        card4,
  output logic [3:0]        hands_left,
`ifdef POKER_DEALER_PRESET_EN
  input  logic              preset_load,
  input  logic [29:0]       preset_hand,
`endif
  output logic              reshuffle
);
  state_t state, nxt;
  logic [2:0] k;
  logic [DECK_N-1:0] used;
  card_t [HAND_N-1:0] cards;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-7:0] lfsr_unused;
  card_t cand;
  logic [5:0] idx;
  logic take, go, pre, xfer, last;
  assign cand = lfsr_q[5:0];
  assign lfsr_unused = lfsr_q[LFSR_W-1:6];
  assign idx = card_idx(cand);
  assign take = state == DRAW && cand[3:0] >= RANK_MIN && cand[3:0] <= RANK_MAX && !used[idx];
`ifdef POKER_DEALER_PRESET_EN
  assign pre = state == IDLE && !seed_load && preset_load;
`else
  assign pre = 1'b0;
`endif
  assign go = state == IDLE && !seed_load && !pre && start;
  assign xfer = state == HOLD && hand_ready;
  assign last = hands_left == 4'd1;
  assign busy = state != IDLE;
  assign hand_valid = state == HOLD;
  assign {card4, card3, card2, card1, card0} = cards;
  poker_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (state == DRAW),
    .load (state == IDLE && seed_load),
    .seed (seed_in == '0 ? SEED : seed_in),
    .q    (lfsr_q)
  );
  always_comb
    nxt = pre ? HOLD : go ? DRAW : (take && k == 3'(HAND_N - 1)) ? HOLD : xfer ? IDLE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      used <= '0;
      cards <= '0;
      hands_left <= HANDS_FULL;
      reshuffle <= 1'b0;
    end else begin
      state <= nxt;
      reshuffle <= xfer && last;
      if (go) cards <= '0;
      if (take) begin
        cards[k] <= cand;
        used[idx] <= 1'b1;
        k <= k + 3'd1;
      end
      if (xfer) begin
        k <= '0;
        hands_left <= last ? HANDS_FULL : hands_left - 4'd1;
        if (last) used <= '0;
      end
`ifdef POKER_DEALER_PRESET_EN
      if (pre) cards <= preset_hand;
`endif
    end
  end
endmodule

// File: tb/tb_poker_dealer.sv
// tb_poker_dealer: randomized deal sequences checked against a deck-occupancy model, optionally with POKER_DEALER_PRESET_EN
module tb_poker_dealer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic seed_load = 1'b0;
  logic hand_ready = 1'b0;
  logic [15:0] seed_in = '0;
  logic busy, hand_valid, reshuffle;
  logic [5:0] card0, card1, card2, card3, card4;
  logic [3:0] hands_left;
`ifdef POKER_DEALER_PRESET_EN
  logic preset_load = 1'b0;
  logic [29:0] preset_hand = '0;
`endif
  logic [29:0] hand;
  int vectors = 0;
  int miscompares = 0;
  bit used_m[52];
  int hands_exp = 10;
  logic [5:0] seq[$];
  logic [5:0] want[$];
  assign hand = {card4, card3, card2, card1, card0};
  always #5 clk = ~clk;
  poker_dealer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .busy       (busy),
    .hand_valid (hand_valid),
    .hand_ready (hand_ready),
    .card0      (card0),
    .card1      (card1),
    .card2      (card2),
    .card3      (card3),
    .card4      (card4),
    .hands_left (hands_left),
`ifdef POKER_DEALER_PRESET_EN
    .preset_load(preset_load),
    .preset_hand(preset_hand),
`endif
    .reshuffle  (reshuffle)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model;
    foreach (used_m[i]) used_m[i] = 1'b0;
    hands_exp = 10;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    seed_load = 1'b0;
    hand_ready = 1'b0;
    tick;
    rst = 1'b0;
    clear_model;
  endtask
  task automatic load_seed(input logic [15:0] s, input bit with_start);
    seed_in = s;
    seed_load = 1'b1;
    start = with_start;
    tick;
    seed_load = 1'b0;
    start = 1'b0;
    check("seed_load_no_start", busy, 0);
  endtask
  task automatic deal_hand(input int hold_cyc, input bit poke);
    int cyc;
    int idx;
    logic [29:0] snap;
    logic [5:0] c;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    check("draw_busy", busy, 1);
    check("draw_clear", hand, 0);
    check("reshuffle_len", reshuffle, 0);
    while (!hand_valid && cyc < 70000) begin
      tick;
      cyc++;
    end
    if (!hand_valid) begin
      check("deal_timeout", 0, 1);
      return;
    end
    check("latency_min", cyc >= 6, 1);
    snap = hand;
    for (int i = 0; i < 5; i++) begin
      c = snap[i*6 +: 6];
      check("rank_range", c[3:0] >= 4'd1 && c[3:0] <= 4'd13, 1);
      idx = int'(c[5:4]) * 13 + int'(c[3:0]) - 1;
      if (idx >= 0 && idx < 52) begin
        check("card_unused", used_m[idx], 0);
        used_m[idx] = 1'b1;
      end
      seq.push_back(c);
    end
    for (int i = 0; i < hold_cyc; i++) begin
      if (poke) start = 1'($urandom_range(0, 1));
      tick;
      check("hold_valid", hand_valid, 1);
      check("hold_stable", hand, snap);
    end
    start = 1'b0;
    hand_ready = 1'b1;
    tick;
    hand_ready = 1'b0;
    hands_exp--;
    check("xfer_valid", hand_valid, 0);
    check("xfer_busy", busy, 0);
    check("reshuffle", reshuffle, hands_exp == 0);
    if (hands_exp == 0) clear_model;
    check("hands_left", hands_left, hands_exp);
    check("idle_keeps", hand, snap);
    if (poke) begin
      tick;
      check("no_queue", busy, 0);
    end
  endtask
  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cyc;
    do_reset;
    check("rst_valid", hand_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hands_left", hands_left, 10);
    check("rst_cards", hand, 0);
    check("rst_reshuffle", reshuffle, 0);
    deal_hand(0, 0);
    for (int h = 0; h < 9; h++) deal_hand($urandom_range(0, 3), 0);
    do_reset;
    for (int h = 0; h < 10; h++) deal_hand(0, 0);
    check("after_reshuffle", hands_left, 10);
    tick;
    check("reshuffle_once", reshuffle, 0);
    deal_hand(0, 0);
    deal_hand(20, 1);
    do_reset;
    load_seed(16'h1234, 0);
    seq.delete();
    for (int h = 0; h < 3; h++) deal_hand($urandom_range(0, 2), 0);
    want = seq;
    do_reset;
    load_seed(16'h1234, 1);
    seq.delete();
    for (int h = 0; h < 3; h++) deal_hand($urandom_range(0, 2), 0);
    check("seed_len", seq.size(), want.size());
    for (int i = 0; i < want.size() && i < seq.size(); i++) check("seed_repeat", seq[i], want[i]);
    do_reset;
    seq.delete();
    deal_hand(0, 0);
    want = seq;
    do_reset;
    load_seed(16'h0000, 0);
    seq.delete();
    deal_hand(0, 0);
    for (int i = 0; i < want.size() && i < seq.size(); i++) check("seed_zero", seq[i], want[i]);
    do_reset;
    deal_hand(0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!(card2 != 6'h00 && card3 == 6'h00) && cyc < 70000) begin
      tick;
      cyc++;
    end
    check("k3_reached", card2 != 6'h00 && card3 == 6'h00 && busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_cards", hand, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", hand_valid, 0);
    check("midrst_hands_left", hands_left, 10);
    clear_model;
    deal_hand(1, 0);
    do_reset;
    load_seed(16'($urandom_range(1, 65535)), 0);
    for (int h = 0; h < 12; h++) deal_hand($urandom_range(0, 3), 1'($urandom_range(0, 1)));
`ifdef POKER_DEALER_PRESET_EN
    do_reset;
    preset_hand = {6'h0D, 6'h1D, 6'h2D, 6'h3D, 6'h01};
    preset_load = 1'b1;
    tick;
    preset_load = 1'b0;
    check("preset_valid", hand_valid, 1);
    check("preset_cards", hand, {6'h0D, 6'h1D, 6'h2D, 6'h3D, 6'h01});
    check("preset_hands_left", hands_left, 10);
    hand_ready = 1'b1;
    tick;
    hand_ready = 1'b0;
    check("preset_xfer", hand_valid, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
